// File: rtl/reg_bank_arbiter.sv
// Round-robin arbitrated access to a single-port register bank.
// One grant per cycle: writes commit at the grant edge, reads return
// registered data one cycle later tagged with the requester index.

// One bank register; reset clears it, write enable loads it.
module reg_bank_arbiter_cell #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] q
);

    // Storage register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= wdata;
    end

endmodule

module reg_bank_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic [ID_WIDTH-1:0]              rd_id
);

    // The winning access for this cycle.
    typedef struct packed {
        logic                  vld;
        logic                  we;
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } acc_t;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] bank_q;
    logic [NUM_REGS-1:0]                 reg_we;
    logic [NUM_REQ-1:0]                  gnt_raw;
    logic [ID_WIDTH-1:0]                 ptr;
    logic [DATA_WIDTH-1:0]               rd_sel;
    logic                                rd_fire;
    acc_t                                acc;

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;

    // Round-robin search starting at the priority pointer; first hit wins.
    always_comb begin
        int idx;
        idx     = 0;
        acc     = '0;
        gnt_raw = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!acc.vld && req[idx]) begin
                acc.vld     = 1'b1;
                acc.we      = req_we[idx];
                acc.id      = ID_WIDTH'(idx);
                acc.addr    = addr_v[idx];
                acc.wdata   = wdata_v[idx];
                gnt_raw[idx] = 1'b1;
            end
        end
    end

    // Reset masks the grant so no requester thinks it was served.
    assign gnt = rst ? '0 : gnt_raw;

    // Out-of-range addresses match no cell, so such writes vanish.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        assign reg_we[r] = acc.vld && acc.we && (acc.addr == ADDR_WIDTH'(r));

        reg_bank_arbiter_cell #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .we    (reg_we[r]),
            .wdata (acc.wdata),
            .q     (bank_q[r])
        );
    end

    // Read mux; an address with no matching register reads as zero.
    always_comb begin
        rd_sel = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (acc.addr == ADDR_WIDTH'(r)) rd_sel = bank_q[r];
        end
    end

    assign rd_fire = acc.vld && !acc.we;

    // Pointer moves just past the last winner; holds when idle.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (acc.vld)
            ptr <= (acc.id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : acc.id + 1'b1;
    end

    // Read return stage; data/id hold while idle, reset squashes in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_id    <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= rd_sel;
                rd_id   <= acc.id;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: directed vector table, a reset-squash
// sequence and randomized traffic against a behavioural model. Two
// instances run side by side: a full 8-register bank and a 6-register bank
// so that addresses 6/7 are out of range on the second.
module tb_reg_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req, req_we;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt8, gnt6;
    logic [7:0]  rd_data8, rd_data6;
    logic        rd_valid8, rd_valid6;
    logic [1:0]  rd_id8, rd_id6;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_bank_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .ID_WIDTH(2), .NUM_REGS(8), .ADDR_WIDTH(3)) u_dut8 (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt8), .rd_data(rd_data8), .rd_valid(rd_valid8), .rd_id(rd_id8));

    reg_bank_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .ID_WIDTH(2), .NUM_REGS(6), .ADDR_WIDTH(3)) u_dut6 (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt6), .rd_data(rd_data6), .rd_valid(rd_valid6), .rd_id(rd_id6));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: bank contents as arrays, pointer as an integer.
    int         m_ptr;
    logic [7:0] m_b8[8];
    logic [7:0] m_b6[8];
    logic       m_vld;
    logic [1:0] m_id;
    logic [7:0] m_d8, m_d6;

    function automatic int pick(input logic [3:0] rq);
        for (int off = 0; off < 4; off++) begin
            int i;
            i = (m_ptr + off) % 4;
            if (rq[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] rq, input logic [3:0] w,
                              input logic [11:0] a, input logic [31:0] d);
        int k, ad;
        if (r) begin
            m_ptr = 0;
            for (int i = 0; i < 8; i++) begin m_b8[i] = 8'h00; m_b6[i] = 8'h00; end
            m_vld = 1'b0; m_id = 2'd0; m_d8 = 8'h00; m_d6 = 8'h00;
        end else begin
            k = pick(rq);
            m_vld = 1'b0;
            if (k >= 0) begin
                m_ptr = (k + 1) % 4;
                ad = int'(a[k*3 +: 3]);
                if (w[k]) begin
                    m_b8[ad] = d[k*8 +: 8];
                    if (ad < 6) m_b6[ad] = d[k*8 +: 8];
                end else begin
                    m_vld = 1'b1;
                    m_id  = 2'(k);
                    m_d8  = m_b8[ad];
                    m_d6  = (ad < 6) ? m_b6[ad] : 8'h00;
                end
            end
        end
    endtask

    // One clock: drive, compare both DUTs with the model mid-cycle,
    // optionally raise reset late in the cycle, then advance the model.
    task automatic cycle(input logic r, input logic [3:0] rq, input logic [3:0] w,
                         input logic [11:0] a, input logic [31:0] d, input logic late,
                         output logic [3:0] g, output logic v, output logic [1:0] id,
                         output logic [7:0] d8, output logic [7:0] d6);
        int k;
        logic [3:0] eg;
        rst = r; req = rq; req_we = w; req_addr = a; req_wdata = d;
        @(negedge clk);
        k  = pick(rq);
        eg = (r || k < 0) ? 4'b0000 : 4'(1 << k);
        chk("gnt8", 32'(gnt8), 32'(eg));
        chk("gnt6", 32'(gnt6), 32'(eg));
        chk("rd_valid8", 32'(rd_valid8), 32'(m_vld));
        chk("rd_valid6", 32'(rd_valid6), 32'(m_vld));
        chk("rd_id8", 32'(rd_id8), 32'(m_id));
        chk("rd_id6", 32'(rd_id6), 32'(m_id));
        chk("rd_data8", 32'(rd_data8), 32'(m_d8));
        chk("rd_data6", 32'(rd_data6), 32'(m_d6));
        g = gnt8; v = rd_valid8; id = rd_id8; d8 = rd_data8; d6 = rd_data6;
        if (late) rst = 1'b1;
        @(posedge clk);
        model_edge(r | late, rq, w, a, d);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic        vld;
        logic [1:0]  id;
        logic [7:0]  d8;
        logic [7:0]  d6;
    } vec_t;

    vec_t tv[24];

    initial begin
        logic [3:0] g;
        logic       v;
        logic [1:0] id;
        logic [7:0] d8, d6;

        // Expected outputs are those visible during the cycle the inputs are applied.
        tv[0]  = '{1, 4'b1111, 4'b0000, 12'o3333, 32'h0,        4'b0000, 0, 2'd0, 8'h00, 8'h00};
        tv[1]  = '{1, 4'b0000, 4'b0000, 12'o3333, 32'h0,        4'b0000, 0, 2'd0, 8'h00, 8'h00};
        tv[2]  = '{0, 4'b0001, 4'b0000, 12'o3335, 32'h0,        4'b0001, 0, 2'd0, 8'h00, 8'h00};
        tv[3]  = '{0, 4'b0000, 4'b0000, 12'o3333, 32'h0,        4'b0000, 1, 2'd0, 8'h00, 8'h00};
        tv[4]  = '{0, 4'b0100, 4'b0100, 12'o3333, 32'h00A50000, 4'b0100, 0, 2'd0, 8'h00, 8'h00};
        tv[5]  = '{0, 4'b0010, 4'b0000, 12'o3333, 32'h0,        4'b0010, 0, 2'd0, 8'h00, 8'h00};
        tv[6]  = '{0, 4'b0000, 4'b0000, 12'o3333, 32'h0,        4'b0000, 1, 2'd1, 8'hA5, 8'hA5};
        tv[7]  = '{1, 4'b0000, 4'b0000, 12'o3333, 32'h0,        4'b0000, 0, 2'd1, 8'hA5, 8'hA5};
        tv[8]  = '{0, 4'b1111, 4'b0000, 12'o3333, 32'h0,        4'b0001, 0, 2'd0, 8'h00, 8'h00};
        tv[9]  = '{0, 4'b1111, 4'b0000, 12'o3333, 32'h0,        4'b0010, 1, 2'd0, 8'h00, 8'h00};
        tv[10] = '{0, 4'b1111, 4'b0000, 12'o3333, 32'h0,        4'b0100, 1, 2'd1, 8'h00, 8'h00};
        tv[11] = '{0, 4'b1111, 4'b0000, 12'o3333, 32'h0,        4'b1000, 1, 2'd2, 8'h00, 8'h00};
        tv[12] = '{0, 4'b1111, 4'b0000, 12'o3333, 32'h0,        4'b0001, 1, 2'd3, 8'h00, 8'h00};
        tv[13] = '{0, 4'b1111, 4'b0000, 12'o3333, 32'h0,        4'b0010, 1, 2'd0, 8'h00, 8'h00};
        tv[14] = '{0, 4'b1111, 4'b0000, 12'o3333, 32'h0,        4'b0100, 1, 2'd1, 8'h00, 8'h00};
        tv[15] = '{0, 4'b1111, 4'b0000, 12'o3333, 32'h0,        4'b1000, 1, 2'd2, 8'h00, 8'h00};
        tv[16] = '{0, 4'b0000, 4'b0000, 12'o3333, 32'h0,        4'b0000, 1, 2'd3, 8'h00, 8'h00};
        tv[17] = '{0, 4'b0010, 4'b0000, 12'o3333, 32'h0,        4'b0010, 0, 2'd3, 8'h00, 8'h00};
        tv[18] = '{0, 4'b1001, 4'b0000, 12'o3333, 32'h0,        4'b1000, 1, 2'd1, 8'h00, 8'h00};
        tv[19] = '{0, 4'b0001, 4'b0000, 12'o3333, 32'h0,        4'b0001, 1, 2'd3, 8'h00, 8'h00};
        tv[20] = '{0, 4'b0000, 4'b0000, 12'o3333, 32'h0,        4'b0000, 1, 2'd0, 8'h00, 8'h00};
        tv[21] = '{0, 4'b0001, 4'b0001, 12'o3337, 32'h000000FF, 4'b0001, 0, 2'd0, 8'h00, 8'h00};
        tv[22] = '{0, 4'b0001, 4'b0000, 12'o3337, 32'h0,        4'b0001, 0, 2'd0, 8'h00, 8'h00};
        tv[23] = '{0, 4'b0000, 4'b0000, 12'o3333, 32'h0,        4'b0000, 1, 2'd0, 8'hFF, 8'h00};

        rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        @(posedge clk);
        model_edge(1'b1, 4'b0, 4'b0, 12'h0, 32'h0);
        #1;

        for (int i = 0; i < 24; i++) begin
            cycle(tv[i].rst, tv[i].req, tv[i].we, tv[i].addr, tv[i].wdata, 1'b0, g, v, id, d8, d6);
            chk($sformatf("tv%0d gnt", i),      32'(g),  32'(tv[i].gnt));
            chk($sformatf("tv%0d rd_valid", i), 32'(v),  32'(tv[i].vld));
            chk($sformatf("tv%0d rd_id", i),    32'(id), 32'(tv[i].id));
            chk($sformatf("tv%0d rd_data8", i), 32'(d8), 32'(tv[i].d8));
            chk($sformatf("tv%0d rd_data6", i), 32'(d6), 32'(tv[i].d6));
        end

        // Reset lands on the edge that would complete requester 3's read.
        cycle(1'b0, 4'b1000, 4'b1000, 12'o2333, 32'h5A000000, 1'b0, g, v, id, d8, d6);
        chk("sq write gnt", 32'(g), 32'(4'b1000));
        cycle(1'b0, 4'b1000, 4'b0000, 12'o2333, 32'h0, 1'b1, g, v, id, d8, d6);
        chk("sq read gnt", 32'(g), 32'(4'b1000));
        cycle(1'b1, 4'b0000, 4'b0000, 12'o2222, 32'h0, 1'b0, g, v, id, d8, d6);
        chk("sq squashed rd_valid", 32'(v), 32'(1'b0));
        cycle(1'b0, 4'b1111, 4'b0000, 12'o2222, 32'h0, 1'b0, g, v, id, d8, d6);
        chk("sq post-reset gnt", 32'(g), 32'(4'b0001));
        cycle(1'b0, 4'b0000, 4'b0000, 12'o2222, 32'h0, 1'b0, g, v, id, d8, d6);
        chk("sq rd_valid", 32'(v), 32'(1'b1));
        chk("sq rd_id", 32'(id), 32'(2'd0));
        chk("sq cleared data", 32'(d8), 32'(8'h00));

        // Random traffic, occasional reset (some arriving late in the cycle).
        for (int n = 0; n < 400; n++) begin
            logic r, late;
            r    = ($urandom_range(0, 39) == 0);
            late = !r && ($urandom_range(0, 49) == 0);
            cycle(r, 4'($urandom), 4'($urandom), 12'($urandom), $urandom, late, g, v, id, d8, d6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares one single-port register bank (NUM_REGS x DATA_WIDTH) among NUM_REQ requesters.
- Each cycle, a round-robin arbiter grants at most one requester access to the bank.
- A granted request performs either a write (commits at that edge) or a read (data returned registered, one cycle later, tagged with requester ID).
- Sits between datapath clients and the register storage; clients never touch the bank directly.

Parameters:
- DATA_WIDTH, 8, width of each register and of the data buses.
- NUM_REQ, 4, number of requesters.
- ID_WIDTH, 2, width of requester ID; NUM_REQ <= 2**ID_WIDTH.
- NUM_REGS, 8, number of registers in the bank.
- ADDR_WIDTH, 3, register address width; NUM_REGS <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- req  input  NUM_REQ  per-requester request; held high until granted.
- req_we  input  NUM_REQ  per-requester op: 1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- gnt  output  NUM_REQ  one-hot grant, combinational from req and the priority pointer.
- rd_data  output  DATA_WIDTH  read result, registered.
- rd_valid  output  1  one-cycle pulse qualifying rd_data.
- rd_id  output  ID_WIDTH  requester index that owns rd_data.

Behaviour:
Reset (rst high at posedge):
- All bank registers cleared to 0.
- Priority pointer set to 0; rd_data, rd_valid and rd_id set to 0.
- gnt is forced to all-zero while rst is high.
- A read granted in the cycle before reset produces no rd_valid; it is squashed.

Arbitration:
- Priority pointer p. The requester granted is the first i with req[i]=1, searching p, p+1, ... NUM_REQ-1, 0, ..., p-1.
- gnt is one-hot or zero, and is all-zero when req is zero.
- After a grant to requester k, p <= (k+1) mod NUM_REQ. With no grant, p holds.
- A continuously held request is granted within NUM_REQ cycles (no starvation).
- Requester handshake: the grant completes the transaction in that cycle. The requester drops req or presents a new op on the next cycle. A req left high is treated as a new request.

Write (gnt[k]=1, req_we[k]=1):
- bank[addr_k] <= wdata_k at that edge.
- rd_valid is 0 on the next cycle.

Read (gnt[k]=1, req_we[k]=0):
- On the next cycle: rd_data = bank[addr_k], rd_valid = 1, rd_id = k.
- Latency is exactly one cycle from the grant edge.
- Back-to-back grants produce back-to-back rd_valid pulses.

Ordering:
- A read granted in the cycle after a write to the same address returns the new value.
- Only one access per cycle, so no same-cycle read/write hazard exists.

Out-of-range address (addr >= NUM_REGS):
- Write is dropped, and the grant is still consumed.
- Read returns rd_data = 0 with rd_valid = 1.

Idle outputs:
- When rd_valid = 0, rd_data and rd_id hold their previous values.
- Consumers qualify with rd_valid only.

Test Plan:
- Reset then read: assert rst 2 cycles, then req[0] read addr 5 -> gnt=0001, next cycle rd_valid=1, rd_id=0, rd_data=0x00.
- Write/read-back: req[2] write addr 3 data 0xA5, then next cycle req[1] read addr 3 -> gnt=0100 then 0010; rd_data=0xA5, rd_id=1 one cycle after the read grant.
- Round-robin fairness: req=1111 held 8 cycles (all reads) -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; rd_id sequence 0,1,2,3,0,1,2,3, each lagging its grant by one cycle.
- Pointer skip: after a grant to requester 1, drive req=1001 -> gnt=1000 (requester 3 before requester 0); next cycle req=0001 -> gnt=0001.
- Out-of-range: NUM_REGS=6; requester 0 writes addr 7 data 0xFF, then reads addr 7 -> rd_data=0x00, rd_valid=1; bank[0..5] unchanged.
- Reset mid-read: requester 3 read granted, rst high on the following edge -> rd_valid stays 0, the bank reads back 0 afterwards, and the next grant with req=1111 is gnt=0001.
